// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM sequencer: mode encoding, LED count and duty type.
package led_pkg;

   localparam int unsigned LED_COUNT     = 4;
   localparam int unsigned PWM_BITS_DEF  = 8;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_BLINK   = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_CHASE   = 2'd3
   } mode_e;

   typedef logic [PWM_BITS_DEF-1:0] duty_t;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler; o_step_tick pulses for one cycle each time the count wraps.
module led_tick_gen #(
   parameter int unsigned CLK_FREQ = 32000000,
   parameter int unsigned STEP_HZ  = 64
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_step_tick
);

   localparam int unsigned DIV  = CLK_FREQ / STEP_HZ;
   localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_step_tick = (r_cnt == LAST);

endmodule

// File: rtl/led_pwm_sequencer.sv
// Four-LED PWM output stage with off/blink/breathe/chase modes, commanded through a
// valid/ready handshake and applied only on a PWM period boundary.
module led_pwm_sequencer
   import led_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = 32000000,
   parameter int unsigned STEP_HZ     = 64,
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned BLINK_STEPS = 32,
   parameter int unsigned BREATHE_INC = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           cmd_mode,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   output logic [1:0]           mode_active,
   output logic [LED_COUNT-1:0] led
);

   localparam int unsigned SW = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;
   localparam logic [SW-1:0]       STEP_LAST    = SW'(BLINK_STEPS - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX     = '1;
   localparam logic [PWM_BITS:0]   DUTY_MAX_EXT = {1'b0, DUTY_MAX};
   localparam logic [PWM_BITS:0]   INC_EXT      = (PWM_BITS + 1)'(BREATHE_INC);
   localparam logic [PWM_BITS-1:0] INC_N        = PWM_BITS'(BREATHE_INC);

   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic                r_cmd_ready;
   mode_e               r_pend_mode;
   mode_e               r_mode;
   logic [PWM_BITS-1:0] r_level;
   logic                r_dir_down;
   logic [SW-1:0]       r_step_cnt;
   logic                r_blink_lit;
   logic [1:0]          r_chase_idx;
   logic [LED_COUNT-1:0][PWM_BITS-1:0] r_duty;
   logic [LED_COUNT-1:0] r_led;

   logic                w_step_tick;
   logic                w_pwm_wrap;
   logic                w_accept;
   logic                w_apply;
   logic [PWM_BITS:0]   w_level_ext;
   mode_e               w_mode_d;
   logic [PWM_BITS-1:0] w_level_d;
   logic                w_dir_down_d;
   logic [SW-1:0]       w_step_cnt_d;
   logic                w_blink_lit_d;
   logic [1:0]          w_chase_idx_d;
   logic [LED_COUNT-1:0][PWM_BITS-1:0] w_duty_d;

   led_tick_gen #(
      .CLK_FREQ (CLK_FREQ),
      .STEP_HZ  (STEP_HZ)
   ) u_tick_gen (
      .i_clk       (clk),
      .i_rst       (rst),
      .o_step_tick (w_step_tick)
   );

   assign w_pwm_wrap  = (r_pwm_cnt == '0);
   assign w_accept    = cmd_valid & r_cmd_ready;
   // Pending exists exactly while ready is low, so an accept on a wrap cycle waits a full period.
   assign w_apply     = ~r_cmd_ready & w_pwm_wrap;
   assign w_level_ext = {1'b0, r_level};

   always_comb begin
      w_mode_d      = r_mode;
      w_level_d     = r_level;
      w_dir_down_d  = r_dir_down;
      w_step_cnt_d  = r_step_cnt;
      w_blink_lit_d = r_blink_lit;
      w_chase_idx_d = r_chase_idx;
      if (w_apply) begin
         w_mode_d      = r_pend_mode;
         w_level_d     = '0;
         w_dir_down_d  = 1'b0;
         w_step_cnt_d  = '0;
         w_blink_lit_d = 1'b1;
         w_chase_idx_d = 2'd0;
      end else if (w_step_tick) begin
         if (r_step_cnt == STEP_LAST) begin
            w_step_cnt_d  = '0;
            w_blink_lit_d = ~r_blink_lit;
            w_chase_idx_d = r_chase_idx + 2'd1;
         end else begin
            w_step_cnt_d = r_step_cnt + 1'b1;
         end
         // Saturate at either end and turn around; the level never wraps.
         if (!r_dir_down) begin
            if ((DUTY_MAX_EXT - w_level_ext) <= INC_EXT) begin
               w_level_d    = DUTY_MAX;
               w_dir_down_d = 1'b1;
            end else begin
               w_level_d = r_level + INC_N;
            end
         end else begin
            if (w_level_ext <= INC_EXT) begin
               w_level_d    = '0;
               w_dir_down_d = 1'b0;
            end else begin
               w_level_d = r_level - INC_N;
            end
         end
      end
   end

   // Duty is derived from next-state values so a newly applied mode takes effect immediately.
   always_comb begin
      w_duty_d = '0;
      for (int i = 0; i < int'(LED_COUNT); i++) begin
         unique case (w_mode_d)
            MODE_OFF:     w_duty_d[i] = '0;
            MODE_BLINK:   w_duty_d[i] = w_blink_lit_d ? DUTY_MAX : '0;
            MODE_BREATHE: w_duty_d[i] = w_level_d;
            MODE_CHASE:   w_duty_d[i] = (w_chase_idx_d == 2'(i)) ? DUTY_MAX : '0;
            default:      w_duty_d[i] = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pwm_cnt   <= '0;
         r_cmd_ready <= 1'b1;
         r_pend_mode <= MODE_OFF;
         r_mode      <= MODE_OFF;
         r_level     <= '0;
         r_dir_down  <= 1'b0;
         r_step_cnt  <= '0;
         r_blink_lit <= 1'b1;
         r_chase_idx <= 2'd0;
         r_duty      <= '0;
         r_led       <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
         if (w_accept) begin
            r_pend_mode <= mode_e'(cmd_mode);
            r_cmd_ready <= 1'b0;
         end else if (w_apply) begin
            r_cmd_ready <= 1'b1;
         end
         r_mode      <= w_mode_d;
         r_level     <= w_level_d;
         r_dir_down  <= w_dir_down_d;
         r_step_cnt  <= w_step_cnt_d;
         r_blink_lit <= w_blink_lit_d;
         r_chase_idx <= w_chase_idx_d;
         if (w_pwm_wrap) begin
            r_duty <= w_duty_d;
         end
         for (int i = 0; i < int'(LED_COUNT); i++) begin
            r_led[i] <= (r_pwm_cnt < r_duty[i]) | (r_duty[i] == DUTY_MAX);
         end
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign mode_active = r_mode;
   assign led         = r_led;

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Directed bench: per-period LED on-count vectors plus handshake, collision and reset sequences.
module tb_led_pwm_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] cmd_mode = 2'd0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] mode_active;
   logic [3:0] led;

   int errors = 0;
   int checks = 0;
   int tb_cnt = 0;

   typedef struct {
      bit          new_cmd;
      logic [1:0]  mode;
      logic [19:0] exp_on;
   } vec_t;

   vec_t vecs[24];

   always #5 clk = ~clk;

   led_pwm_sequencer #(
      .CLK_FREQ    (1024),
      .STEP_HZ     (64),
      .PWM_BITS    (4),
      .BLINK_STEPS (2),
      .BREATHE_INC (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_mode    (cmd_mode),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .mode_active (mode_active),
      .led         (led)
   );

   task automatic step();
      @(posedge clk);
      if (rst) tb_cnt = 0;
      else tb_cnt = (tb_cnt + 1) % 16;
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [19:0] all_on(input int n);
      logic [4:0] v;
      v = 5'(n);
      return {v, v, v, v};
   endfunction

   function automatic logic [19:0] one_on(input int idx);
      logic [19:0] v;
      v = '0;
      v[idx*5 +: 5] = 5'd16;
      return v;
   endfunction

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!cmd_ready && n < 40) begin
         step();
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL %s: cmd_ready still 0 after 40 cycles, required 1", name);
      end
   endtask

   task automatic send_cmd(input logic [1:0] m);
      wait_ready("pre_cmd_ready");
      cmd_mode  = m;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      wait_ready("apply_timeout");
      check("apply_mode", 32'(mode_active), 32'(m));
   endtask

   // Window starts when tb_cnt==2: 16 samples covering compares at cnt 1..15,0 of one duty.
   task automatic measure(output logic [19:0] got);
      int c[4];
      for (int i = 0; i < 4; i++) c[i] = 0;
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < 4; i++) c[i] += int'(led[i]);
         step();
      end
      got = {5'(c[3]), 5'(c[2]), 5'(c[1]), 5'(c[0])};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] got;
      int low;

      vecs[0]  = '{1'b1, 2'd1, all_on(16)};
      vecs[1]  = '{1'b0, 2'd1, all_on(0)};
      vecs[2]  = '{1'b0, 2'd1, all_on(0)};
      vecs[3]  = '{1'b0, 2'd1, all_on(16)};
      vecs[4]  = '{1'b0, 2'd1, all_on(16)};
      vecs[5]  = '{1'b0, 2'd1, all_on(0)};
      vecs[6]  = '{1'b1, 2'd2, all_on(4)};
      vecs[7]  = '{1'b0, 2'd2, all_on(8)};
      vecs[8]  = '{1'b0, 2'd2, all_on(12)};
      vecs[9]  = '{1'b0, 2'd2, all_on(16)};
      vecs[10] = '{1'b0, 2'd2, all_on(11)};
      vecs[11] = '{1'b0, 2'd2, all_on(7)};
      vecs[12] = '{1'b0, 2'd2, all_on(3)};
      vecs[13] = '{1'b0, 2'd2, all_on(0)};
      vecs[14] = '{1'b0, 2'd2, all_on(4)};
      vecs[15] = '{1'b1, 2'd3, one_on(0)};
      vecs[16] = '{1'b0, 2'd3, one_on(1)};
      vecs[17] = '{1'b0, 2'd3, one_on(1)};
      vecs[18] = '{1'b0, 2'd3, one_on(2)};
      vecs[19] = '{1'b0, 2'd3, one_on(2)};
      vecs[20] = '{1'b0, 2'd3, one_on(3)};
      vecs[21] = '{1'b0, 2'd3, one_on(3)};
      vecs[22] = '{1'b0, 2'd3, one_on(0)};
      vecs[23] = '{1'b1, 2'd0, all_on(0)};

      // Reset values
      rst = 1'b1;
      step();
      check("rst_led", 32'(led), 32'h0);
      check("rst_ready", 32'(cmd_ready), 32'h1);
      check("rst_mode", 32'(mode_active), 32'h0);
      step();
      step();
      rst = 1'b0;

      // Handshake accepted at pwm_cnt==5; valid stays high with a different mode while busy
      while (tb_cnt != 5) step();
      cmd_mode  = 2'd1;
      cmd_valid = 1'b1;
      step();
      cmd_mode = 2'd3;
      low = 0;
      while (!cmd_ready && low < 40) begin
         low++;
         step();
      end
      cmd_valid = 1'b0;
      check("hs_ready_low_cycles", 32'(low), 32'd11);
      check("hs_mode", 32'(mode_active), 32'd1);
      step();
      check("hs_led", 32'(led), 32'hF);
      repeat (40) step();
      check("hs_no_second_accept", 32'(mode_active), 32'd1);
      check("hs_ready_idle", 32'(cmd_ready), 32'd1);

      // Per-period LED on-count vectors
      for (int r = 0; r < 24; r++) begin
         if (vecs[r].new_cmd) begin
            send_cmd(vecs[r].mode);
            repeat (17) step();
         end
         measure(got);
         check($sformatf("row%0d", r), 32'(got), 32'(vecs[r].exp_on));
      end

      // Collision: accept on the wrap cycle applies one full period later
      while (tb_cnt != 0) step();
      check("coll_ready_pre", 32'(cmd_ready), 32'd1);
      cmd_mode  = 2'd2;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      check("coll_not_now", 32'(mode_active), 32'd0);
      low = 0;
      while (!cmd_ready && low < 40) begin
         low++;
         step();
      end
      check("coll_ready_low_cycles", 32'(low), 32'd16);
      check("coll_mode", 32'(mode_active), 32'd2);

      // Reset mid-BREATHE with a CHASE command pending
      repeat (40) step();
      cmd_mode  = 2'd3;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      check("mid_pending", 32'(cmd_ready), 32'd0);
      rst = 1'b1;
      step();
      check("mid_rst_led", 32'(led), 32'h0);
      check("mid_rst_mode", 32'(mode_active), 32'd0);
      check("mid_rst_ready", 32'(cmd_ready), 32'd1);
      step();
      step();
      rst = 1'b0;
      repeat (40) step();
      check("mid_discard_mode", 32'(mode_active), 32'd0);
      check("mid_discard_led", 32'(led), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
